// File: rtl/shot_resolver_if.sv
// Attack/arm handshake and result bus between the turn FSM and one shot_resolver.
// The turn FSM side uses master; the resolver uses slave.
interface shot_resolver_if #(
  parameter int unsigned CELLS = 16,
  parameter int unsigned LW    = $clog2(CELLS + 1)
);
  logic             arm;
  logic [CELLS-1:0] ship;
  logic             fire;
  logic [CELLS-1:0] shot;
  logic             ready;
  logic             busy;
  logic             done;
  logic             hit;
  logic             miss;
  logic             invalid;
  logic             repeat_shot;
  logic             live;
  logic [LW-1:0]    lives;
  logic [CELLS-1:0] hits;

  modport master (
    output arm, ship, fire, shot,
    input  ready, busy, done, hit, miss, invalid, repeat_shot, live, lives, hits
  );

  modport slave (
    input  arm, ship, fire, shot,
    output ready, busy, done, hit, miss, invalid, repeat_shot, live, lives, hits
  );
endinterface

// File: rtl/shot_resolver.sv
// Per-player shot resolver: counts ships on arm, then serially scans each attack word
// and classifies it as invalid / repeat / hit / miss while tracking hits and lives.
module shot_resolver #(
  parameter int unsigned CELLS = 16,
  parameter int unsigned LW    = $clog2(CELLS + 1)
) (
  input  logic           clk,
  input  logic           clr,
  shot_resolver_if.slave bus
);

  localparam int unsigned IW = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CELLS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNT   = 3'd1,
    S_READY   = 3'd2,
    S_CHECK   = 3'd3,
    S_RESOLVE = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CELLS-1:0] ship_r;
  logic [CELLS-1:0] shot_r;
  logic [CELLS-1:0] hits_q;
  logic [LW-1:0]    lives_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    pos_q;
  logic [1:0]       ones_q;
  logic             live_q;
  logic             done_q;
  logic             hit_q;
  logic             miss_q;
  logic             invalid_q;
  logic             repeat_q;

  logic ready_c;
  logic busy_c;
  logic do_arm_c;
  logic do_fire_c;
  logic do_count_c;
  logic do_check_c;
  logic do_resolve_c;
  logic scan_last_c;

  logic [LW-1:0] count_sum_c;
  logic          res_invalid_c;
  logic          res_repeat_c;
  logic          res_hit_c;
  logic          res_miss_c;
  logic [LW-1:0] lives_after_c;

  assign scan_last_c = (idx_q == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; arm wins over fire in READY
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.arm) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (scan_last_c) state_d = S_READY;
      end
      S_READY: begin
        if (bus.arm)       state_d = S_COUNT;
        else if (bus.fire) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (scan_last_c) state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State decode and datapath strobes
  always_comb begin
    ready_c      = 1'b0;
    busy_c       = 1'b0;
    do_arm_c     = 1'b0;
    do_fire_c    = 1'b0;
    do_count_c   = 1'b0;
    do_check_c   = 1'b0;
    do_resolve_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        do_arm_c = bus.arm;
      end
      S_COUNT: begin
        busy_c     = 1'b1;
        do_count_c = 1'b1;
      end
      S_READY: begin
        ready_c   = 1'b1;
        do_arm_c  = bus.arm;
        do_fire_c = bus.fire & ~bus.arm;
      end
      S_CHECK: begin
        busy_c     = 1'b1;
        do_check_c = 1'b1;
      end
      S_RESOLVE: begin
        busy_c       = 1'b1;
        do_resolve_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Shot classification from the scan results
  always_comb begin
    count_sum_c   = lives_q + LW'(ship_r[idx_q]);
    res_invalid_c = (ones_q != 2'd1);
    res_repeat_c  = ~res_invalid_c & hits_q[pos_q];
    res_hit_c     = ~res_invalid_c & ~hits_q[pos_q] & ship_r[pos_q];
    res_miss_c    = ~res_invalid_c & ~hits_q[pos_q] & ~ship_r[pos_q];
    lives_after_c = res_hit_c ? (lives_q - LW'(1)) : lives_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (clr) begin
      ship_r    <= '0;
      shot_r    <= '0;
      hits_q    <= '0;
      lives_q   <= '0;
      idx_q     <= '0;
      pos_q     <= '0;
      ones_q    <= '0;
      live_q    <= 1'b1;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      invalid_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (do_arm_c) begin
        ship_r    <= bus.ship;
        hits_q    <= '0;
        lives_q   <= '0;
        idx_q     <= '0;
        hit_q     <= 1'b0;
        miss_q    <= 1'b0;
        invalid_q <= 1'b0;
        repeat_q  <= 1'b0;
      end

      if (do_fire_c) begin
        shot_r    <= bus.shot;
        idx_q     <= '0;
        ones_q    <= '0;
        hit_q     <= 1'b0;
        miss_q    <= 1'b0;
        invalid_q <= 1'b0;
        repeat_q  <= 1'b0;
      end

      if (do_count_c) begin
        lives_q <= count_sum_c;
        idx_q   <= scan_last_c ? '0 : idx_q + IW'(1);
        if (scan_last_c) live_q <= (count_sum_c != '0);
      end

      // One-count saturates at 2: anything past one set bit is already invalid
      if (do_check_c) begin
        if (shot_r[idx_q]) begin
          if (ones_q != 2'd2) ones_q <= ones_q + 2'd1;
          if (ones_q == 2'd0) pos_q <= idx_q;
        end
        idx_q <= scan_last_c ? '0 : idx_q + IW'(1);
      end

      if (do_resolve_c) begin
        done_q    <= 1'b1;
        invalid_q <= res_invalid_c;
        repeat_q  <= res_repeat_c;
        hit_q     <= res_hit_c;
        miss_q    <= res_miss_c;
        lives_q   <= lives_after_c;
        live_q    <= (lives_after_c != '0);
        if (res_hit_c) hits_q[pos_q] <= 1'b1;
      end
    end
  end

  assign bus.ready       = ready_c;
  assign bus.busy        = busy_c;
  assign bus.done        = done_q;
  assign bus.hit         = hit_q;
  assign bus.miss        = miss_q;
  assign bus.invalid     = invalid_q;
  assign bus.repeat_shot = repeat_q;
  assign bus.live        = live_q;
  assign bus.lives       = lives_q;
  assign bus.hits        = hits_q;

endmodule

// File: doc/shot_resolver.md
# shot_resolver

Per-player shot-resolution controller for the Basys battleship game. On arm it latches the player's ship-position mask from the load registers and serially counts ships to set the life count. On each fire request from the turn FSM's attack state it serially scans the opponent's attack word, decides invalid / repeat / hit / miss, updates the hit mask and lives, and drives the `live` flag back to the turn FSM. Two instances are used, one per player.

## Interface

- `CELLS`, default 16: board cells, one per switch; must be ≥ 2.
- `LW`, default `$clog2(CELLS+1)`: width of the life counter.

- `clk`  in  1  system clock; single clock domain.
- `clr`  in  1  reset; synchronous, active-high.
- `arm`  in  1  latch `ship` and start the life count (load-state strobe).
- `ship`  in  CELLS  own ship-position mask; sampled only when `arm` is accepted.
- `fire`  in  1  resolve the attack held on `shot`.
- `shot`  in  CELLS  opponent attack word; sampled only when `fire` is accepted.
- `ready`  out  1  idle in READY and able to accept `fire`.
- `busy`  out  1  in COUNT, CHECK or RESOLVE.
- `done`  out  1  one-cycle pulse when a shot result is valid.
- `hit`, `miss`, `invalid`, `repeat_shot`  out  1 each  result flags; at most one is high.
- `live`  out  1  player still has unsunk cells (feeds the turn FSM's Liv input).
- `lives`  out  LW  remaining unsunk cells.
- `hits`  out  CELLS  cells of `ship` already hit.

## Operation

- States: IDLE, COUNT, READY, CHECK, RESOLVE. A scan index `idx` runs from 0 to CELLS-1.
- IDLE (reset state)
  - `fire` is ignored.
  - `arm` latches `ship` into `ship_r`, clears `hits`, `lives` and `idx`, and moves to COUNT.
- COUNT
  - Each cycle: `lives += ship_r[idx]`, then `idx++`.
  - After processing `idx == CELLS-1`, move to READY and register `live = (lives != 0)`.
  - `arm` and `fire` are ignored.
- READY
  - `arm` has priority over `fire`. It re-arms: same action as from IDLE.
  - Otherwise `fire` latches `shot` into `shot_r`, clears `idx`, the one-count and all result flags, and moves to CHECK.
- CHECK
  - Each cycle, if `shot_r[idx]` is set: the one-count increments, saturating at 2, and `pos` takes `idx` on the first one.
  - After `idx == CELLS-1`, move to RESOLVE.
  - `arm` and `fire` are ignored.
- RESOLVE: one cycle. Register exactly one flag, pulse `done`, and return to READY.
  - One-count ≠ 1 → `invalid`. Covers zero bits and multiple bits set.
  - Else `hits[pos]` already set → `repeat_shot`.
  - Else `ship_r[pos]` set → `hit`, set `hits[pos]`, `lives -= 1`.
  - Else → `miss`.
- `invalid`, `repeat_shot` and `miss` leave `hits`, `lives` and `live` unchanged.
- `live` is re-registered in RESOLVE from the post-update `lives`. `lives` never decrements below 0: a hit is impossible when `lives == 0`, because every ship cell is already in `hits`.
- Result flags hold until the next accepted `fire` or `arm`. `arm` also clears them.
- Arming with `ship == 0` gives `lives = 0` and `live = 0` once COUNT completes.

## Timing

- Reset values, applied on the first `clk` edge with `clr = 1`: state IDLE, `idx = 0`, `ready = 0`, `busy = 0`, `done = 0`, all result flags 0, `live = 1`, `lives = 0`, `hits = 0`.
- `clr` in any state, including mid COUNT or CHECK, aborts immediately to the reset values. There is no partial update.
- `arm` accepted at edge k:
  - `busy = 1` from k.
  - `lives` and `live` are final and `ready = 1` from edge k+CELLS.
- `fire` accepted at edge k:
  - `busy = 1` from k through edge k+CELLS+1.
  - RESOLVE is entered at edge k+CELLS.
  - At edge k+CELLS+1 the result flags, `hits`, `lives` and `live` update and `done` goes high.
  - `done` drops at edge k+CELLS+2.
  - `ready` is high again from edge k+CELLS+1, so back-to-back fires are accepted every CELLS+2 cycles.
- `fire` held high is accepted again at the first READY edge. The turn FSM pulses it for one cycle only.
- `ready` and `busy` are decoded from registered state. All other outputs are registers.

## Test plan

- Reset then `arm` with `ship = 16'h0007` → 16 cycles later `ready = 1`, `lives = 3`, `live = 1`, `hits = 0`.
- From that state, `fire` with `shot = 16'h0001` → `done` 17 cycles later with `hit = 1`, `hits = 16'h0001`, `lives = 2`. The same shot again → `repeat_shot = 1`, `lives` stays 2.
- `shot = 16'h0000` → `invalid`. `shot = 16'h0003` → `invalid`. `shot = 16'h0010` → `miss`. In all three, `hits` and `lives` are unchanged.
- Fire `16'h0002` then `16'h0004` → `lives = 0` and `live = 0` at the second `done`. `arm` with `ship = 16'h0000` → `lives = 0`, `live = 0`.
- Assert `clr` at CHECK cycle 5 → next cycle all outputs equal the reset values, `hits = 0`, and no `done` pulse appears.
- `arm` and `fire` in the same READY cycle → COUNT is entered, no `done` pulse, and `hits` is cleared.
